pixel_streamer: RTL and testbench

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/pixel_streamer.sv | 104 ++++++++++
 tb/tb_pixel_streamer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// Pixel streamer: buffers escape counts as colours and emits a raster stream.
// Optional macro PIXEL_STREAMER_PALETTE_EN selects a 16-entry palette over greyscale.
module pixel_streamer #(
    parameter int H_PIXELS   = 640,
    parameter int V_PIXELS   = 480,
    parameter int MAX_ITER   = 255,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  iter_count,
    input  logic        iter_valid,
    output logic        iter_ready,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [9:0]  X_LAST  = 10'(H_PIXELS - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_PIXELS - 1);
    localparam logic [7:0]  ITER_IN = 8'(MAX_ITER);

    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          live;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [23:0]   colour;
    logic          push;
    logic          pop;

    // live keeps iter_ready low through reset and until the first cycle after it
    assign iter_ready = en && live && (count < FULL);
    assign pix_valid  = (count != '0);
    assign push       = iter_valid && iter_ready;
    assign pop        = pix_valid && pix_ready;

`ifdef PIXEL_STREAMER_PALETTE_EN
    logic [23:0] palette [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            palette[i] = {4'(i), 4'h0, ~{4'(i), 4'h0}, 8'h80};
        end
    end

    always_comb begin
        colour = palette[iter_count[3:0]];
        if (iter_count == ITER_IN) colour = '0;
    end
`else
    always_comb begin
        colour = {3{iter_count}};
        if (iter_count == ITER_IN) colour = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= colour;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            live       <= 1'b0;
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
        end else begin
            live       <= 1'b1;
            frame_done <= pop && (x == X_LAST) && (y == Y_LAST);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    assign pix_data = pix_valid ? mem[rd_ptr] : '0;
    assign pix_sof  = pix_valid && (x == '0) && (y == '0);
    assign pix_eol  = pix_valid && (x == X_LAST);

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer: two instances (4x2 and 8x4) share one stimulus
// stream and are compared every cycle against a queue-based model.
module tb_pixel_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [7:0]  iter_count = '0;
    logic        iter_valid = 1'b0;
    logic        pix_ready = 1'b1;

    logic        iter_ready_a, pix_valid_a, sof_a, eol_a, fd_a;
    logic        iter_ready_b, pix_valid_b, sof_b, eol_b, fd_b;
    logic [23:0] pix_data_a, pix_data_b;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] q[$];
    int   pos_a = 0;
    int   pos_b = 0;
    logic fd_a_exp = 1'b0;
    logic fd_b_exp = 1'b0;
    logic live_m = 1'b0;
    int   fd_a_cnt = 0;
    int   fd_b_cnt = 0;

    always #5 clk = ~clk;

    pixel_streamer #(.H_PIXELS(4), .V_PIXELS(2), .MAX_ITER(255), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .iter_count(iter_count), .iter_valid(iter_valid), .iter_ready(iter_ready_a),
        .pix_data(pix_data_a), .pix_valid(pix_valid_a), .pix_ready(pix_ready),
        .pix_sof(sof_a), .pix_eol(eol_a), .frame_done(fd_a)
    );

    pixel_streamer #(.H_PIXELS(8), .V_PIXELS(4), .MAX_ITER(255), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .iter_count(iter_count), .iter_valid(iter_valid), .iter_ready(iter_ready_b),
        .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready),
        .pix_sof(sof_b), .pix_eol(eol_b), .frame_done(fd_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] colour(input logic [7:0] c);
        logic [3:0] i;
        i = c[3:0];
        if (c == 8'd255) return 24'h000000;
`ifdef PIXEL_STREAMER_PALETTE_EN
        return {i, 4'h0, ~{i, 4'h0}, 8'h80};
`else
        return {c, c, c};
`endif
    endfunction

    // Compare current outputs with the model, then advance the model to the next edge
    always @(negedge clk) begin : mon
        logic        ev;
        logic        er;
        logic        pop;
        logic        push;
        logic [23:0] ed;
        ev = (q.size() != 0);
        er = en && live_m && (q.size() < 4);
        ed = ev ? q[0] : 24'h0;
        check("pix_valid_a", pix_valid_a, ev);
        check("pix_valid_b", pix_valid_b, ev);
        check("iter_ready_a", iter_ready_a, er);
        check("iter_ready_b", iter_ready_b, er);
        check("pix_data_a", pix_data_a, ed);
        check("pix_data_b", pix_data_b, ed);
        check("sof_a", sof_a, ev && pos_a == 0);
        check("eol_a", eol_a, ev && (pos_a % 4) == 3);
        check("sof_b", sof_b, ev && pos_b == 0);
        check("eol_b", eol_b, ev && (pos_b % 8) == 7);
        check("frame_done_a", fd_a, fd_a_exp);
        check("frame_done_b", fd_b, fd_b_exp);
        if (fd_a) fd_a_cnt++;
        if (fd_b) fd_b_cnt++;
        if (rst) begin
            q.delete();
            pos_a = 0;
            pos_b = 0;
            fd_a_exp = 1'b0;
            fd_b_exp = 1'b0;
            live_m = 1'b0;
        end else begin
            pop  = ev && pix_ready;
            push = er && iter_valid;
            fd_a_exp = pop && pos_a == 7;
            fd_b_exp = pop && pos_b == 31;
            if (pop) begin
                void'(q.pop_front());
                pos_a = (pos_a + 1) % 8;
                pos_b = (pos_b + 1) % 32;
            end
            if (push) q.push_back(colour(iter_count));
            live_m = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] c);
        bit acc;
        acc = 1'b0;
        iter_count = c;
        iter_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = iter_ready_a;
            @(posedge clk);
            #1;
        end
        iter_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        pix_ready = 1'b1;
        for (int i = 0; i < 300 && q.size() != 0; i++) cyc(1);
        check("drain_empty", q.size(), 0);
        cyc(2);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cyc(n);
        rst = 1'b0;
    endtask

    initial begin : stim
        int  n0a;
        int  n0b;
        int  sent;
        bit  t;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        // first pixel, then inside-set value
        send(8'h10);
        send(8'd255);
        drain();

        // backpressure: fill, hold off a fifth push, then release
        pix_ready = 1'b0;
        send(8'h21);
        send(8'h42);
        send(8'h63);
        send(8'h84);
        iter_count = 8'hA5;
        iter_valid = 1'b1;
        cyc(3);
        pix_ready = 1'b1;
        send(8'hA5);
        drain();

        // continuous 4x2 frame plus the start of the next one
        do_reset(1);
        n0a = fd_a_cnt;
        for (int i = 0; i < 9; i++) send(8'(i * 7 + 1));
        drain();
        check("frames_4x2", fd_a_cnt - n0a, 1);

        // enable low blocks pushes
        en = 1'b0;
        iter_count = 8'h33;
        iter_valid = 1'b1;
        cyc(3);
        iter_valid = 1'b0;
        en = 1'b1;
        cyc(1);

        // reset mid-frame with pixels still buffered
        do_reset(1);
        pix_ready = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        pix_ready = 1'b1;
        cyc(3);
        pix_ready = 1'b0;
        send(8'h05);
        do_reset(1);
        pix_ready = 1'b1;
        send(8'h06);
        drain();

        // random handshakes over three 8x4 frames
        do_reset(2);
        n0a = fd_a_cnt;
        n0b = fd_b_cnt;
        sent = 0;
        iter_count = 8'($urandom);
        iter_valid = ($urandom % 2) == 1;
        pix_ready = ($urandom % 2) == 1;
        for (int i = 0; i < 5000 && sent < 96; i++) begin
            @(negedge clk);
            t = iter_valid && iter_ready_a;
            @(posedge clk);
            #1;
            if (t) begin
                sent++;
                iter_count = 8'($urandom);
            end
            iter_valid = (sent < 96) && (($urandom % 2) == 1);
            pix_ready = ($urandom % 2) == 1;
        end
        iter_valid = 1'b0;
        check("rand_sent", sent, 96);
        drain();
        check("frames_8x4", fd_b_cnt - n0b, 3);
        check("frames_4x2_rand", fd_a_cnt - n0a, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
